hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard unit for the rv32imc pipeline; owns ID-stage stall/bubble decisions.
//  Handles load-use stalls of configurable length and multi-cycle (mul/div) RAW/WAW hazards
//  via a per-register pending scoreboard, a structural limit on outstanding long ops,
//  memory freeze and flush. Also counts bubble cycles. Sits between ID and EX.
// PARAMETERS
//  NUM_REGS         32  architectural registers tracked (x0 never pending)
//  ADDR_W            5  register address width, $clog2(NUM_REGS)
//  LOAD_USE_CYCLES   1  bubbles per load-use hazard (1..7; dmem latency - 1 + 1)
//  MAX_PENDING       2  max outstanding long-latency ops (1..NUM_REGS-1)
//  CNT_W            32  width of bubble-cycle perf counter
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous reset, active-high
//  id_rs1_addr   in   ADDR_W  ID source 1
//  id_rs2_addr   in   ADDR_W  ID source 2
//  id_rs1_used   in   1       ID instr reads rs1
//  id_rs2_used   in   1       ID instr reads rs2
//  id_rd_addr    in   ADDR_W  ID destination
//  id_rd_we      in   1       ID instr writes rd
//  id_is_long    in   1       ID instr is mul/div (long op)
//  ex_valid      in   1       EX holds a real instr (not bubble)
//  ex_mem_read   in   1       EX instr is a load
//  ex_rd_addr    in   ADDR_W  EX destination
//  long_issue    in   1       long op enters the mul/div unit this cycle
//  long_issue_rd in   ADDR_W  its destination
//  long_wb_valid in   1       long op writes back this cycle
//  long_wb_rd    in   ADDR_W  its destination
//  dmem_stall    in   1       data memory not ready: freeze pipeline
//  flush         in   1       branch/jump redirect, kills ID
//  id_bubble     out  1       1 = ctrl_mux selects stall_out
//  id_reg_we     out  1       IF/ID register write enable
//  pc_we         out  1       PC write enable
//  pending_full  out  1       outstanding long ops == MAX_PENDING
//  bubble_cnt    out  CNT_W   saturating count of cycles with id_bubble=1
// BEHAVIOUR
//  - Reset: pending[]=0, pend_cnt=0, lu_cnt=0, bubble_cnt=0. Outputs combinational from state
//    and inputs; while rst=1 force id_bubble=0, id_reg_we=1, pc_we=1.
//  - match(a) = a!=0 && ((id_rs1_used && id_rs1_addr==a) || (id_rs2_used && id_rs2_addr==a)).
//  - Load-use: lu_hit = ex_valid && ex_mem_read && match(ex_rd_addr) && lu_cnt==0.
//    On lu_hit (not frozen/flushed), lu_cnt <= LOAD_USE_CYCLES-1. Hazard asserted while
//    lu_hit || lu_cnt!=0; lu_cnt decrements each unfrozen cycle. LOAD_USE_CYCLES=1 gives
//    one bubble with no counter state used.
//  - Scoreboard: pending[r] set on long_issue (r=long_issue_rd, r!=0), cleared on long_wb_valid.
//    Same-reg set and clear in one cycle: set wins. pend_cnt tracks set bits (+1/-1/both=hold).
//  - RAW: match(r) && pending[r] && !(long_wb_valid && long_wb_rd==r)
//    (writeback same cycle is covered by regfile write-through, so no stall).
//  - WAW: id_rd_we && id_rd_addr!=0 && pending[id_rd_addr] (same wb exemption).
//  - Structural: id_is_long && pend_cnt==MAX_PENDING && !long_wb_valid.
//  - hazard = load-use || RAW || WAW || structural.
//  - Priority, highest first:
//    - dmem_stall: pc_we=0, id_reg_we=0, id_bubble=0; lu_cnt and bubble_cnt hold.
//      Scoreboard still updates: long unit runs independently.
//    - flush: pc_we=1, id_reg_we=1, id_bubble=1 (kills ID); lu_cnt <= 0.
//      Scoreboard unchanged; in-flight long ops complete.
//    - hazard: pc_we=0, id_reg_we=0, id_bubble=1.
//    - none: pc_we=1, id_reg_we=1, id_bubble=0.
//  - bubble_cnt += 1 on each cycle with id_bubble=1 and !rst; saturates at all-ones.
//  - long_wb_valid for a non-pending reg is ignored. long_issue when full is a caller error;
//    pend_cnt saturates at MAX_PENDING.
// TESTING
//  - LOAD_USE_CYCLES=1: EX lw x5, ID add x6,x5,x1 -> 1 cycle id_bubble=1, pc_we=0; then release.
//  - LOAD_USE_CYCLES=3: same pair -> exactly 3 bubble cycles; bubble_cnt +3.
//    Load to x0 or unused rs2 -> no stall.
//  - long_issue x7, ID reads x7 -> stall until long_wb_valid x7.
//    Release in the wb cycle itself; pending[7]=0 next cycle.
//  - MAX_PENDING=2: issue x3,x4, ID div -> pending_full=1, stall.
//    Wb x3 same cycle -> no stall.
//  - dmem_stall during a 3-cycle load-use stall -> bubble=0, lu_cnt frozen.
//    Total bubbles still 3 after release.
//  - flush during hazard -> bubble=1, pc_we=1, lu_cnt cleared. rst mid-stall -> all state 0 next cycle.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID/EX hazard-unit signal bundle: decode operands, EX load info, long-op unit events, stall controls.
interface hazard_scoreboard_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
);
  logic [ADDR_W-1:0] id_rs1_addr;
  logic [ADDR_W-1:0] id_rs2_addr;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [ADDR_W-1:0] id_rd_addr;
  logic              id_rd_we;
  logic              id_is_long;
  logic              ex_valid;
  logic              ex_mem_read;
  logic [ADDR_W-1:0] ex_rd_addr;
  logic              long_issue;
  logic [ADDR_W-1:0] long_issue_rd;
  logic              long_wb_valid;
  logic [ADDR_W-1:0] long_wb_rd;
  logic              dmem_stall;
  logic              flush;
  logic              id_bubble;
  logic              id_reg_we;
  logic              pc_we;
  logic              pending_full;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_rd_addr, id_rd_we,
           id_is_long, ex_valid, ex_mem_read, ex_rd_addr, long_issue, long_issue_rd,
           long_wb_valid, long_wb_rd, dmem_stall, flush,
    input  id_bubble, id_reg_we, pc_we, pending_full, bubble_cnt
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_rd_addr, id_rd_we,
           id_is_long, ex_valid, ex_mem_read, ex_rd_addr, long_issue, long_issue_rd,
           long_wb_valid, long_wb_rd, dmem_stall, flush,
    output id_bubble, id_reg_we, pc_we, pending_full, bubble_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: load-use stall counter, long-op pending scoreboard (RAW/WAW/structural),
// memory freeze and flush priority, saturating bubble-cycle counter.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned ADDR_W          = 5,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned MAX_PENDING     = 2,
  parameter int unsigned CNT_W           = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam int unsigned     PC_W      = $clog2(MAX_PENDING + 1);
  localparam int unsigned     LU_W      = 3;
  localparam logic [LU_W-1:0] LU_RELOAD = LU_W'(LOAD_USE_CYCLES - 1);
  localparam logic [PC_W-1:0] PEND_MAX  = PC_W'(MAX_PENDING);

  logic [NUM_REGS-1:0] pending, pending_nxt;
  logic [PC_W-1:0]     pend_cnt, pend_cnt_nxt;
  logic [LU_W-1:0]     lu_cnt, lu_cnt_nxt;
  logic [CNT_W-1:0]    bubble_cnt;

  logic [ADDR_W-1:0] rs1, rs2, rd, ex_rd, iss_rd, wb_rd;
  logic lu_hit, lu_haz, raw, waw, structural, hazard;
  logic set_en, clr_en;
  logic bubble_c, id_reg_we_c, pc_we_c;

  assign rs1    = bus.id_rs1_addr;
  assign rs2    = bus.id_rs2_addr;
  assign rd     = bus.id_rd_addr;
  assign ex_rd  = bus.ex_rd_addr;
  assign iss_rd = bus.long_issue_rd;
  assign wb_rd  = bus.long_wb_rd;

  // ID instruction reads a non-zero register a
  function automatic logic src_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] s1,
                                     input logic u1, input logic [ADDR_W-1:0] s2, input logic u2);
    return (a != '0) && ((u1 && (s1 == a)) || (u2 && (s2 == a)));
  endfunction

  // Writeback this cycle reaches ID through regfile write-through
  function automatic logic wb_covers(input logic [ADDR_W-1:0] a, input logic v,
                                     input logic [ADDR_W-1:0] w);
    return v && (w == a);
  endfunction

  always_comb begin
    lu_hit = bus.ex_valid && bus.ex_mem_read && (lu_cnt == '0) &&
             src_match(ex_rd, rs1, bus.id_rs1_used, rs2, bus.id_rs2_used);
    lu_haz = lu_hit || (lu_cnt != '0);
    raw = (bus.id_rs1_used && (rs1 != '0) && pending[rs1] &&
           !wb_covers(rs1, bus.long_wb_valid, wb_rd)) ||
          (bus.id_rs2_used && (rs2 != '0) && pending[rs2] &&
           !wb_covers(rs2, bus.long_wb_valid, wb_rd));
    waw = bus.id_rd_we && (rd != '0) && pending[rd] && !wb_covers(rd, bus.long_wb_valid, wb_rd);
    structural = bus.id_is_long && (pend_cnt == PEND_MAX) && !bus.long_wb_valid;
    hazard = lu_haz || raw || waw || structural;
  end

  // Pipeline control, freeze > flush > hazard; reset forces free-running
  always_comb begin
    bubble_c    = 1'b0;
    id_reg_we_c = 1'b1;
    pc_we_c     = 1'b1;
    if (!rst) begin
      if (bus.dmem_stall) begin
        id_reg_we_c = 1'b0;
        pc_we_c     = 1'b0;
      end else if (bus.flush) begin
        bubble_c = 1'b1;
      end else if (hazard) begin
        bubble_c    = 1'b1;
        id_reg_we_c = 1'b0;
        pc_we_c     = 1'b0;
      end
    end
  end

  always_comb begin
    lu_cnt_nxt = lu_cnt;
    if (!bus.dmem_stall) begin
      if (bus.flush)             lu_cnt_nxt = '0;
      else if (lu_hit)           lu_cnt_nxt = LU_RELOAD;
      else if (lu_cnt != '0)     lu_cnt_nxt = lu_cnt - LU_W'(1);
    end
  end

  // Scoreboard runs regardless of freeze/flush; same-register set beats clear
  always_comb begin
    set_en      = bus.long_issue && (iss_rd != '0);
    clr_en      = bus.long_wb_valid && pending[wb_rd];
    pending_nxt = pending;
    if (clr_en) pending_nxt[wb_rd]  = 1'b0;
    if (set_en) pending_nxt[iss_rd] = 1'b1;
    pend_cnt_nxt = pend_cnt;
    if (set_en && !clr_en && (pend_cnt != PEND_MAX))
      pend_cnt_nxt = pend_cnt + PC_W'(1);
    else if (clr_en && !set_en && (pend_cnt != '0))
      pend_cnt_nxt = pend_cnt - PC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      pend_cnt   <= '0;
      lu_cnt     <= '0;
      bubble_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= pend_cnt_nxt;
      lu_cnt   <= lu_cnt_nxt;
      if (bubble_c && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign bus.id_bubble    = bubble_c;
  assign bus.id_reg_we    = id_reg_we_c;
  assign bus.pc_we        = pc_we_c;
  assign bus.pending_full = (pend_cnt == PEND_MAX);
  assign bus.bubble_cnt   = bubble_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: one unit with 1-cycle load-use, one with 3-cycle, sharing the same stimulus.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.ADDR_W(5), .CNT_W(32)) b1 ();
  hazard_scoreboard_if #(.ADDR_W(5), .CNT_W(32)) b3 ();

  hazard_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .LOAD_USE_CYCLES(1), .MAX_PENDING(2), .CNT_W(32))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  hazard_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .LOAD_USE_CYCLES(3), .MAX_PENDING(2), .CNT_W(32))
    dut3 (.clk(clk), .rst(rst), .bus(b3));

  assign b1.id_rs1_addr   = b3.id_rs1_addr;
  assign b1.id_rs2_addr   = b3.id_rs2_addr;
  assign b1.id_rs1_used   = b3.id_rs1_used;
  assign b1.id_rs2_used   = b3.id_rs2_used;
  assign b1.id_rd_addr    = b3.id_rd_addr;
  assign b1.id_rd_we      = b3.id_rd_we;
  assign b1.id_is_long    = b3.id_is_long;
  assign b1.ex_valid      = b3.ex_valid;
  assign b1.ex_mem_read   = b3.ex_mem_read;
  assign b1.ex_rd_addr    = b3.ex_rd_addr;
  assign b1.long_issue    = b3.long_issue;
  assign b1.long_issue_rd = b3.long_issue_rd;
  assign b1.long_wb_valid = b3.long_wb_valid;
  assign b1.long_wb_rd    = b3.long_wb_rd;
  assign b1.dmem_stall    = b3.dmem_stall;
  assign b1.flush         = b3.flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b3.id_rs1_addr = '0; b3.id_rs2_addr = '0; b3.id_rs1_used = 1'b0; b3.id_rs2_used = 1'b0;
    b3.id_rd_addr = '0; b3.id_rd_we = 1'b0; b3.id_is_long = 1'b0;
    b3.ex_valid = 1'b0; b3.ex_mem_read = 1'b0; b3.ex_rd_addr = '0;
    b3.long_issue = 1'b0; b3.long_issue_rd = '0; b3.long_wb_valid = 1'b0; b3.long_wb_rd = '0;
    b3.dmem_stall = 1'b0; b3.flush = 1'b0;
  endtask

  task automatic load_ex(input logic [4:0] r);
    b3.ex_valid = 1'b1; b3.ex_mem_read = 1'b1; b3.ex_rd_addr = r;
  endtask

  task automatic ex_empty();
    b3.ex_valid = 1'b0; b3.ex_mem_read = 1'b0; b3.ex_rd_addr = '0;
  endtask

  task automatic id_reads(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    b3.id_rs1_addr = r1; b3.id_rs1_used = u1; b3.id_rs2_addr = r2; b3.id_rs2_used = u2;
  endtask

  task automatic issue(input logic v, input logic [4:0] r);
    b3.long_issue = v; b3.long_issue_rd = r;
  endtask

  task automatic wb(input logic v, input logic [4:0] r);
    b3.long_wb_valid = v; b3.long_wb_rd = r;
  endtask

  initial begin
    // Reset with a load-use pattern present: controls forced free-running
    rst = 1'b1;
    idle();
    load_ex(5'd5); id_reads(5'd5, 1'b1, 5'd1, 1'b1);
    #2;
    chk("rst_bubble", 32'(b3.id_bubble), 32'd0);
    chk("rst_pc_we", 32'(b3.pc_we), 32'd1);
    chk("rst_id_reg_we", 32'(b3.id_reg_we), 32'd1);
    tick(); tick();
    rst = 1'b0;
    idle();
    #2;
    chk("post_rst_bubble_cnt", b3.bubble_cnt, 32'd0);
    chk("post_rst_full", 32'(b3.pending_full), 32'd0);
    chk("post_rst_pc_we", 32'(b3.pc_we), 32'd1);

    // lw x5 in EX, add x6,x5,x1 in ID
    load_ex(5'd5); id_reads(5'd5, 1'b1, 5'd1, 1'b1); b3.id_rd_addr = 5'd6; b3.id_rd_we = 1'b1;
    #2;
    chk("lu1_bubble", 32'(b1.id_bubble), 32'd1);
    chk("lu1_pc_we", 32'(b1.pc_we), 32'd0);
    chk("lu3_bubble_c0", 32'(b3.id_bubble), 32'd1);
    tick();
    ex_empty();
    #2;
    chk("lu1_release", 32'(b1.id_bubble), 32'd0);
    chk("lu1_release_pc_we", 32'(b1.pc_we), 32'd1);
    chk("lu3_bubble_c1", 32'(b3.id_bubble), 32'd1);
    tick(); #2;
    chk("lu3_bubble_c2", 32'(b3.id_bubble), 32'd1);
    tick(); #2;
    chk("lu3_release", 32'(b3.id_bubble), 32'd0);
    chk("lu3_release_pc_we", 32'(b3.pc_we), 32'd1);
    chk("lu3_bubble_cnt", b3.bubble_cnt, 32'd3);
    chk("lu1_bubble_cnt", b1.bubble_cnt, 32'd1);

    // Loads that must not stall
    idle();
    load_ex(5'd0); id_reads(5'd0, 1'b1, 5'd0, 1'b1);
    #2;
    chk("lu_x0", 32'(b3.id_bubble), 32'd0);
    load_ex(5'd2); id_reads(5'd1, 1'b1, 5'd2, 1'b0);
    #2;
    chk("lu_rs2_unused", 32'(b3.id_bubble), 32'd0);

    // Long op to x7, consumer waits until writeback
    idle();
    issue(1'b1, 5'd7);
    #2; tick();
    issue(1'b0, 5'd0); id_reads(5'd7, 1'b1, 5'd0, 1'b0);
    #2;
    chk("raw_bubble", 32'(b3.id_bubble), 32'd1);
    chk("raw_pc_we", 32'(b3.pc_we), 32'd0);
    tick(); #2;
    chk("raw_hold", 32'(b3.id_bubble), 32'd1);
    tick();
    wb(1'b1, 5'd7);
    #2;
    chk("raw_wb_release", 32'(b3.id_bubble), 32'd0);
    chk("raw_wb_pc_we", 32'(b3.pc_we), 32'd1);
    tick();
    wb(1'b0, 5'd0);
    #2;
    chk("raw_after_wb", 32'(b3.id_bubble), 32'd0);
    chk("pending7_clear", 32'(dut3.pending[7]), 32'd0);
    chk("raw_bubble_cnt", b3.bubble_cnt, 32'd5);

    // Structural limit with two outstanding ops, then WAW
    idle();
    issue(1'b1, 5'd3); #2; tick();
    issue(1'b1, 5'd4); #2; tick();
    issue(1'b0, 5'd0);
    #2;
    chk("full_set", 32'(b3.pending_full), 32'd1);
    b3.id_is_long = 1'b1; b3.id_rd_addr = 5'd8; b3.id_rd_we = 1'b1; id_reads(5'd1, 1'b1, 5'd2, 1'b1);
    #2;
    chk("struct_bubble", 32'(b3.id_bubble), 32'd1);
    wb(1'b1, 5'd3);
    #2;
    chk("struct_wb_release", 32'(b3.id_bubble), 32'd0);
    tick();
    idle();
    b3.id_rd_addr = 5'd4; b3.id_rd_we = 1'b1;
    #2;
    chk("full_drop", 32'(b3.pending_full), 32'd0);
    chk("waw_bubble", 32'(b3.id_bubble), 32'd1);
    wb(1'b1, 5'd4);
    #2;
    chk("waw_wb_release", 32'(b3.id_bubble), 32'd0);
    tick();

    // Same-register set and clear in one cycle: pending survives
    idle();
    issue(1'b1, 5'd9); #2; tick();
    wb(1'b1, 5'd9); #2; tick();
    idle(); id_reads(5'd9, 1'b1, 5'd0, 1'b0);
    #2;
    chk("set_wins", 32'(b3.id_bubble), 32'd1);
    wb(1'b1, 5'd9);
    #2; tick();
    idle();
    #2;
    chk("sb_empty_full", 32'(b3.pending_full), 32'd0);
    chk("sb_bubble_cnt", b3.bubble_cnt, 32'd5);

    // Freeze in the middle of a 3-cycle load-use stall
    load_ex(5'd5); id_reads(5'd5, 1'b1, 5'd0, 1'b0);
    #2;
    chk("frz_start", 32'(b3.id_bubble), 32'd1);
    tick();
    ex_empty(); b3.dmem_stall = 1'b1;
    #2;
    chk("frz_bubble", 32'(b3.id_bubble), 32'd0);
    chk("frz_pc_we", 32'(b3.pc_we), 32'd0);
    chk("frz_id_reg_we", 32'(b3.id_reg_we), 32'd0);
    tick(); tick();
    chk("frz_lu_cnt", 32'(dut3.lu_cnt), 32'd2);
    chk("frz_bubble_cnt", b3.bubble_cnt, 32'd6);
    b3.dmem_stall = 1'b0;
    #2;
    chk("frz_resume_1", 32'(b3.id_bubble), 32'd1);
    tick(); #2;
    chk("frz_resume_2", 32'(b3.id_bubble), 32'd1);
    tick(); #2;
    chk("frz_release", 32'(b3.id_bubble), 32'd0);
    chk("frz_total", b3.bubble_cnt, 32'd8);

    // Flush while load-use counter is running
    load_ex(5'd5);
    #2;
    chk("fl_start", 32'(b3.id_bubble), 32'd1);
    tick();
    ex_empty(); b3.flush = 1'b1;
    #2;
    chk("fl_bubble", 32'(b3.id_bubble), 32'd1);
    chk("fl_pc_we", 32'(b3.pc_we), 32'd1);
    chk("fl_id_reg_we", 32'(b3.id_reg_we), 32'd1);
    tick();
    b3.flush = 1'b0;
    #2;
    chk("fl_lu_cnt", 32'(dut3.lu_cnt), 32'd0);
    chk("fl_after", 32'(b3.id_bubble), 32'd0);
    chk("fl_bubble_cnt", b3.bubble_cnt, 32'd10);

    // Reset in the middle of a stall with a long op outstanding
    idle();
    issue(1'b1, 5'd7); #2; tick();
    issue(1'b0, 5'd0); load_ex(5'd5); id_reads(5'd5, 1'b1, 5'd0, 1'b0);
    #2;
    chk("mid_rst_stall", 32'(b3.id_bubble), 32'd1);
    tick();
    ex_empty(); rst = 1'b1;
    #2;
    chk("mid_rst_bubble", 32'(b3.id_bubble), 32'd0);
    chk("mid_rst_pc_we", 32'(b3.pc_we), 32'd1);
    tick();
    rst = 1'b0; idle();
    #2;
    chk("mid_rst_cnt", b3.bubble_cnt, 32'd0);
    chk("mid_rst_lu", 32'(dut3.lu_cnt), 32'd0);
    chk("mid_rst_pending", dut3.pending, 32'd0);
    chk("mid_rst_full", 32'(b3.pending_full), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
